// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive controller bus: serial line, configuration, sampler handshake and byte outputs.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  RX_IN;
  logic [4:0]            Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  sampled_bit;
  logic [3:0]            edge_cnt;
  logic                  dat_samp_en;
  logic                  busy;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
    input  edge_cnt, dat_samp_en, busy, P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
    output edge_cnt, dat_samp_en, busy, P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_edge_bit_counter.sv
// Oversampling edge counter with bit-end strobe, plus the frame bit counter.
module uart_edge_bit_counter #(
  parameter int unsigned BIT_CNT_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable_i,
  input  logic [4:0]           prescale_i,
  input  logic                 bit_clr_i,
  input  logic                 bit_inc_i,
  output logic [3:0]           edge_cnt_o,
  output logic                 bit_end_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_o
);
  logic [3:0]           edge_q, edge_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic                 last_edge;

  // >= rather than == so an out-of-range Prescale still wraps and cannot stall
  assign last_edge = ({1'b0, edge_q} >= (prescale_i - 5'd1));
  assign bit_end_o = enable_i && last_edge;

  always_comb begin
    edge_d = edge_q;
    if (!enable_i || last_edge) edge_d = '0;
    else                        edge_d = edge_q + 4'd1;
  end

  always_comb begin
    bit_d = bit_q;
    if (bit_clr_i)      bit_d = '0;
    else if (bit_inc_i) bit_d = bit_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame sequencing, LSB-first deserialization, parity/stop checks.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input logic          CLK,
  input logic          RST,
  uart_rx_ctrl_if.slave rx
);
  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, pdata_q, pdata_d;
  logic                  pe_q, pe_d, par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                  dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;
  logic                  cnt_en, bit_end, bit_inc, bit_clr;
  logic [BIT_CNT_W-1:0]  bit_cnt;

  assign cnt_en  = (state_q != IDLE) || !rx.RX_IN;
  assign bit_clr = (state_q == IDLE);

  uart_edge_bit_counter #(.BIT_CNT_W(BIT_CNT_W)) u_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .enable_i   (cnt_en),
    .prescale_i (rx.Prescale),
    .bit_clr_i  (bit_clr),
    .bit_inc_i  (bit_inc),
    .edge_cnt_o (rx.edge_cnt),
    .bit_end_o  (bit_end),
    .bit_cnt_o  (bit_cnt)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    pdata_d   = pdata_q;
    pe_d      = pe_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    bit_inc   = 1'b0;
    dv_d      = 1'b0;
    perr_d    = 1'b0;
    serr_d    = 1'b0;
    unique case (state_q)
      IDLE: if (!rx.RX_IN) begin
        state_d   = START;
        pe_d      = 1'b0;
        par_en_d  = rx.PAR_EN;
        par_typ_d = rx.PAR_TYP;
      end
      START: if (bit_end) state_d = rx.sampled_bit ? IDLE : DATA;
      DATA: if (bit_end) begin
        shift_d = {rx.sampled_bit, shift_q[DATA_WIDTH-1:1]};
        bit_inc = 1'b1;
        if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1))
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (bit_end) begin
        pe_d    = rx.sampled_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD));
        state_d = STOP;
      end
      STOP: if (bit_end) begin
        // Flags are registered here so they pulse in the cycle after the stop bit end
        serr_d  = !rx.sampled_bit;
        perr_d  = pe_q;
        dv_d    = rx.sampled_bit && !pe_q;
        if (dv_d) pdata_d = shift_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      pdata_q   <= '0;
      pe_q      <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      dv_q      <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      pdata_q   <= pdata_d;
      pe_q      <= pe_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      dv_q      <= dv_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
    end
  end

  assign rx.busy        = (state_q != IDLE);
  assign rx.dat_samp_en = (state_q != IDLE);
  assign rx.P_DATA      = pdata_q;
  assign rx.data_valid  = dv_q;
  assign rx.par_err     = perr_q;
  assign rx.stp_err     = serr_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl; the bench stands in for data_sampling on sampled_bit.
module tb_uart_rx_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  logic [7:0]  exp_pdata = 8'h00;

  typedef struct {
    int unsigned cyc;
    logic        dv;
    logic        pe;
    logic        se;
    logic [7:0]  pd;
  } exp_t;
  exp_t sb[$];

  uart_rx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(8), .BIT_CNT_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .rx  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame-end pulse checker: every pulse must match the oldest pending expectation.
  always @(negedge CLK) begin
    if (RST && (bus.data_valid || bus.par_err || bus.stp_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {bus.data_valid, bus.par_err, bus.stp_err}, 3'b000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("data_valid", bus.data_valid, e.dv);
        chk("par_err", bus.par_err, e.pe);
        chk("stp_err", bus.stp_err, e.se);
        chk("P_DATA", bus.P_DATA, e.pd);
        chk("busy_at_end", bus.busy, 1'b0);
      end
    end
  end

  // Drives one frame; sampled_bit shows the wrong value until it is guaranteed settled.
  task automatic send_frame(input logic [7:0] d, input int unsigned p, input logic pen,
                            input logic ptyp, input logic flip_par, input logic stop_val,
                            input int unsigned abort_bits);
    logic        bits [11];
    int unsigned nb;
    int unsigned t0;
    exp_t        e;
    nb = pen ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    bits[9] = (^d) ^ ptyp ^ flip_par;
    bits[nb-1] = stop_val;
    t0 = 0;
    for (int unsigned k = 0; k < nb; k++) begin
      if (abort_bits != 0 && k == abort_bits) return;
      for (int unsigned j = 0; j < p; j++) begin
        @(posedge CLK); #1;
        bus.RX_IN       = bits[k];
        bus.sampled_bit = (j >= p/2 + 2) ? bits[k] : ~bits[k];
        if (k == 0 && j == 0) begin
          t0 = cyc;
          bus.Prescale = 5'(p);
          bus.PAR_EN   = pen;
          bus.PAR_TYP  = ptyp;
          if (abort_bits == 0) begin
            e.cyc = t0 + nb * p;
            e.pe  = pen & flip_par;
            e.se  = ~stop_val;
            e.dv  = ~e.pe & ~e.se;
            if (e.dv) exp_pdata = d;
            e.pd  = exp_pdata;
            sb.push_back(e);
          end
        end else if (k == 0 && j == 1) begin
          bus.PAR_EN  = ~pen;
          bus.PAR_TYP = ~ptyp;
        end
      end
    end
  endtask

  task automatic glitch(input int unsigned p);
    for (int unsigned j = 0; j <= p; j++) begin
      @(posedge CLK); #1;
      bus.Prescale    = 5'(p);
      bus.RX_IN       = (j < 2) ? 1'b0 : 1'b1;
      bus.sampled_bit = (j >= p/2 + 2);
      if (j == p - 1) begin
        @(negedge CLK);
        chk("glitch_busy_mid", bus.busy, 1'b1);
      end else if (j == p) begin
        @(negedge CLK);
        chk("glitch_edge_cnt", bus.edge_cnt, 4'd0);
        chk("glitch_samp_en", bus.dat_samp_en, 1'b0);
        chk("glitch_busy", bus.busy, 1'b0);
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      bus.RX_IN       = 1'b1;
      bus.sampled_bit = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.RX_IN = 1'b1; bus.sampled_bit = 1'b1; bus.Prescale = 5'd8;
    bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_samp_en", bus.dat_samp_en, 1'b0);
    chk("rst_edge_cnt", bus.edge_cnt, 4'd0);
    chk("rst_pdata", bus.P_DATA, 8'h00);
    chk("rst_pulses", {bus.data_valid, bus.par_err, bus.stp_err}, 3'b000);
    RST = 1'b1;
    idle(4);

    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    idle(5);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    idle(5);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    idle(5);
    send_frame(8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    idle(5);
    glitch(8);
    idle(5);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    idle(5);
    send_frame(8'hC3, 16, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    idle(5);

    send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b0, 1'b1, 5);
    @(posedge CLK); #1;
    bus.RX_IN = 1'b0;
    #1 RST = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_samp_en", bus.dat_samp_en, 1'b0);
    chk("mid_rst_edge_cnt", bus.edge_cnt, 4'd0);
    chk("mid_rst_pdata", bus.P_DATA, 8'h00);
    chk("mid_rst_pulses", {bus.data_valid, bus.par_err, bus.stp_err}, 3'b000);
    exp_pdata = 8'h00;
    idle(3);
    @(negedge CLK) RST = 1'b1;
    idle(3);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    idle(20);

    chk("pending_expectations", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller. It sits around the data_sampling block: it drives that block's edge_cnt and dat_samp_en and consumes its majority-voted sampled_bit.
- Detects the start bit and sequences start, data, optional parity and stop bits.
- Deserializes 8 data bits LSB-first.
- Checks parity and stop bits.
- Presents a received byte with a single-cycle valid pulse, or a single-cycle error pulse.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
BIT_CNT_W, 4, width of internal bit counter

Ports:
CLK  in  1  system clock, oversampled at Prescale x baud
RST  in  1  asynchronous, active-low reset
RX_IN  in  1  serial line, idle high
Prescale  in  5  oversampling ratio; supported values 8 and 16; must be stable while busy=1
PAR_EN  in  1  1 = frame contains a parity bit
PAR_TYP  in  1  0 = even, 1 = odd parity
sampled_bit  in  1  voted bit from data_sampling; valid from edge_cnt = Prescale/2+2 of the current bit
edge_cnt  out  4  oversampling edge index within the current bit, 0..Prescale-1
dat_samp_en  out  1  enables data_sampling
busy  out  1  frame in progress
P_DATA  out  8  last good received byte
data_valid  out  1  one-cycle pulse: P_DATA holds a new byte
par_err  out  1  one-cycle pulse: parity mismatch on the frame just ended
stp_err  out  1  one-cycle pulse: stop bit sampled low

Behaviour:
Reset (RST=0, any time, including mid-frame):
- State = IDLE.
- edge_cnt = 0, bit counter = 0, shift register = 0, P_DATA = 0.
- dat_samp_en, busy, data_valid, par_err, stp_err = 0.

Edge counter:
- In IDLE, edge_cnt holds 0.
- Counting is enabled when state != IDLE, or when state == IDLE and RX_IN == 0.
- The detection cycle is edge 0.
- Counter increments every cycle, wrapping from Prescale-1 to 0.
- "Bit end" = counter enabled and edge_cnt == Prescale-1.

Outputs:
- dat_samp_en = busy = (state != IDLE), registered with state.
- Sampled decisions are taken only at bit end, when sampled_bit is guaranteed settled.

States:
- IDLE: RX_IN == 0 -> START. PAR_EN and PAR_TYP are latched in this cycle and used for the whole frame.
- START: at bit end, sampled_bit == 0 -> DATA with bit counter = 0. sampled_bit == 1 is a glitch -> IDLE, with no pulse and no error.
- DATA: at bit end, the shift register shifts right with sampled_bit entering the MSB, so after 8 bits bit0 is the first received bit. The bit counter increments. After bit DATA_WIDTH-1: -> PARITY if latched PAR_EN, else -> STOP.
- PARITY: at bit end, compute the expected bit: even = XOR of the 8 data bits; odd = its inverse. Store pe = (sampled_bit != expected). -> STOP.
- STOP: at bit end, se = ~sampled_bit. -> IDLE.

Frame-end cycle (the cycle after the STOP bit end):
- data_valid = ~pe & ~se; P_DATA is loaded from the shift register only when data_valid = 1.
- par_err = pe, stp_err = se.
- All three are one-cycle pulses; otherwise 0.
- pe is cleared at start detection; it is always 0 when parity is disabled.

Latency:
- Let t0 = the detection cycle.
- Pulse at t0 + 10*Prescale without parity; t0 + 11*Prescale with parity.

Back-to-back frames:
- In the frame-end cycle the state is already IDLE, so RX_IN == 0 in that same cycle starts the next frame.
- No idle bit is required beyond the half stop bit consumed.

Other boundaries:
- P_DATA holds its previous value on an errored frame.
- Prescale outside {8,16} is unsupported. For any value in 6..16 the controller must still return to IDLE; it must never hang.

Decomposition:
Shared package uart_pkg:
- State encoding: IDLE, START, DATA, PARITY, STOP (3-bit).
- DATA_WIDTH default.
- Parity type constants: PAR_EVEN = 0, PAR_ODD = 1.

Sub-module uart_edge_bit_counter:
- Inputs: enable, Prescale.
- Outputs: edge_cnt, bit_end, bit counter with a clear input.
- The FSM, shifter and checks stay in uart_rx_ctrl.
- data_sampling is instantiated alongside it at the receiver top level, not inside.

Test Plan:
1. Prescale=8, PAR_EN=0, frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1), start at t0 -> data_valid=1 and P_DATA=0xA5 exactly at t0+80; par_err=stp_err=0; busy low from t0+80.
2. Prescale=16, PAR_EN=1, PAR_TYP=0 (even), byte 0x3C with parity bit 0 -> data_valid at t0+176, P_DATA=0x3C. Repeat with parity bit 1 -> par_err pulse at t0+176, data_valid=0, P_DATA still 0x3C.
3. Prescale=8, PAR_EN=1, PAR_TYP=1 (odd), byte 0x01 with parity bit 0 and stop bit 0 -> data_valid=0 at t0+88, stp_err=1, par_err=0.
4. Prescale=8, RX_IN low for 2 cycles then high (start glitch) -> back to IDLE at t0+8 with sampled_bit=1; no pulses; edge_cnt=0, dat_samp_en=0.
5. Two back-to-back frames 0x55 then 0xAA, next start bit beginning at t0+80, Prescale=8 -> two data_valid pulses, at t0+80 (P_DATA=0x55) and at t0+160 (P_DATA=0xAA).
6. Assert RST in the DATA state after 4 bits -> all outputs 0 and state IDLE immediately. A clean frame 0x0F after release -> received correctly.
